sfx_sequencer: RTL and testbench

Sound-effect sequencer that sits directly upstream of sound_generator and drives all of its control inputs.
- On a trigger it plays a stored effect: a list of steps, each holding a full parameter set for a programmed number of ticks.
- Game logic only pulses trigger with an effect number; this block does the rest.
- When idle it drives mixer=0, so the speaker is silent.

---
 rtl/sfx_pkg.sv | 85 ++++++++
 rtl/sfx_rom.sv | 38 +++
 rtl/sfx_sequencer.sv | 164 ++++++++++++++++
 tb/tb_sfx_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// sfx_pkg: shared definitions for the sound-effect sequencer.
//   - step-word layout (field offsets/widths, STEP_W)
//   - sequencer state encoding
//   - default effect table and its lookup function used to fill sfx_rom
package sfx_pkg;

    localparam int STEP_W    = 51;

    // Step word: {last, duration, mixer, lfo_shift, noise_sel, vco_sel,
    //             lfo_freq, noise_freq, vco_freq}
    localparam int VCO_LSB   = 0;
    localparam int VCO_W     = 12;
    localparam int NOISE_LSB = 12;
    localparam int NOISE_W   = 12;
    localparam int LFO_LSB   = 24;
    localparam int LFO_W     = 10;
    localparam int VSEL_BIT  = 34;
    localparam int NSEL_BIT  = 35;
    localparam int SHIFT_LSB = 36;
    localparam int SHIFT_W   = 3;
    localparam int MIX_LSB   = 39;
    localparam int MIX_W     = 3;
    localparam int DUR_LSB   = 42;
    localparam int DUR_W     = 8;
    localparam int LAST_BIT  = 50;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        PLAY  = 2'd3
    } state_t;

    function automatic logic [STEP_W-1:0] make_step(
        input logic        last,
        input logic [7:0]  dur,
        input logic [2:0]  mix,
        input logic [2:0]  shift,
        input logic        nsel,
        input logic        vsel,
        input logic [9:0]  lfo,
        input logic [11:0] noise,
        input logic [11:0] vco
    );
        return {last, dur, mix, shift, nsel, vsel, lfo, noise, vco};
    endfunction

    // Default table geometry: 4 effects x 8 steps, flattened as sfx*8+step.
    localparam int TABLE_SFX   = 4;
    localparam int TABLE_STEPS = 8;

    localparam logic [STEP_W-1:0] SFX_TABLE [0:31] = '{
        // sfx0: single VCO blip, 3 ticks
        make_step(1'b1, 8'd3, 3'b001, 3'd0, 1'b0, 1'b0, 10'd0, 12'd0,  12'd250),
        '0, '0, '0, '0, '0, '0, '0,
        // sfx1: rising three-step VCO sweep, 2 ticks each
        make_step(1'b0, 8'd2, 3'b001, 3'd0, 1'b0, 1'b0, 10'd0, 12'd0,  12'd100),
        make_step(1'b0, 8'd2, 3'b001, 3'd0, 1'b0, 1'b0, 10'd0, 12'd0,  12'd200),
        make_step(1'b1, 8'd2, 3'b001, 3'd0, 1'b0, 1'b0, 10'd0, 12'd0,  12'd300),
        '0, '0, '0, '0, '0,
        // sfx2: noise burst; duration 0 plays as a single tick
        make_step(1'b1, 8'd0, 3'b010, 3'd0, 1'b1, 1'b0, 10'd0, 12'd90, 12'd0),
        '0, '0, '0, '0, '0, '0, '0,
        // sfx3: eight one-tick steps, no last flag; ends on the final slot
        make_step(1'b0, 8'd1, 3'b001, 3'd0, 1'b0, 1'b0, 10'd0, 12'd0,  12'd50),
        make_step(1'b0, 8'd1, 3'b001, 3'd0, 1'b0, 1'b0, 10'd0, 12'd0,  12'd100),
        make_step(1'b0, 8'd1, 3'b001, 3'd0, 1'b0, 1'b0, 10'd0, 12'd0,  12'd150),
        make_step(1'b0, 8'd1, 3'b001, 3'd0, 1'b0, 1'b0, 10'd0, 12'd0,  12'd200),
        make_step(1'b0, 8'd1, 3'b001, 3'd0, 1'b0, 1'b0, 10'd0, 12'd0,  12'd250),
        make_step(1'b0, 8'd1, 3'b001, 3'd0, 1'b0, 1'b0, 10'd0, 12'd0,  12'd300),
        make_step(1'b0, 8'd1, 3'b001, 3'd0, 1'b0, 1'b0, 10'd0, 12'd0,  12'd350),
        make_step(1'b0, 8'd1, 3'b001, 3'd0, 1'b0, 1'b0, 10'd0, 12'd0,  12'd400)
    };

    // Entries outside the default table read as all-zero (silent) steps.
    function automatic logic [STEP_W-1:0] table_word(input int sfx, input int step);
        logic [4:0] idx;
        if (sfx >= TABLE_SFX || step >= TABLE_STEPS) begin
            return '0;
        end
        idx = 5'(sfx * TABLE_STEPS + step);
        return SFX_TABLE[idx];
    endfunction

endpackage

// File: rtl/sfx_rom.sv
// sfx_rom: synchronous-read effect ROM, NUM_SFX*STEPS step words filled from
// the sfx_pkg default table.
// Ports:
//   clk   in   clock
//   sfx   in   effect number (upper address part)
//   step  in   step index    (lower address part)
//   data  out  step word, valid one cycle after sfx/step are presented
module sfx_rom
    import sfx_pkg::*;
#(
    parameter int NUM_SFX = 4,
    parameter int STEPS   = 8,
    parameter int SFX_IW  = 2,
    parameter int STEP_IW = 3
) (
    input  logic               clk,
    input  logic [SFX_IW-1:0]  sfx,
    input  logic [STEP_IW-1:0] step,
    output logic [STEP_W-1:0]  data
);

    int sfx_i;
    int step_i;

    always_comb begin
        sfx_i  = int'(sfx);
        step_i = int'(step);
    end

    always_ff @(posedge clk) begin
        if (sfx_i < NUM_SFX && step_i < STEPS) begin
            data <= table_word(sfx_i, step_i);
        end else begin
            data <= '0;
        end
    end

endmodule

// File: rtl/sfx_sequencer.sv
// sfx_sequencer: plays stored sound effects by driving every control input of
// sound_generator. Each effect is a list of steps; a step holds a complete
// parameter set for a programmed number of prescaler ticks.
// Ports:
//   clk, reset (async, active low)
//   trigger, sfx_id    start request; sfx_id sampled when trigger=1
//   busy               high whenever the sequencer is not IDLE
//   done               one-cycle pulse when an effect ends normally
//   lfo_freq, noise_freq, vco_freq, vco_select, noise_select, lfo_shift,
//   mixer              sound_generator controls (mixer = {LFO, Noise, VCO})
//
// Handshake: trigger is a single-cycle strobe with no back-pressure. It is
// accepted in every state and restarts the sequencer at step 0 of sfx_id,
// abandoning any effect in progress without a done pulse.
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int CLK_DIV = 25000,
    parameter int NUM_SFX = 4,
    parameter int STEPS   = 8,
    localparam int SFX_IW  = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1,
    localparam int STEP_IW = (STEPS > 1) ? $clog2(STEPS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trigger,
    input  logic [SFX_IW-1:0] sfx_id,
    output logic              busy,
    output logic              done,
    output logic [9:0]        lfo_freq,
    output logic [11:0]       noise_freq,
    output logic [11:0]       vco_freq,
    output logic              vco_select,
    output logic              noise_select,
    output logic [2:0]        lfo_shift,
    output logic [2:0]        mixer
);

    state_t               state;
    state_t               next_state;
    logic [15:0]          presc;
    logic                 tick;
    logic [SFX_IW-1:0]    sfx_q;
    logic [STEP_IW-1:0]   step_q;
    logic [7:0]           dur_cnt;
    logic                 last_q;
    logic [STEP_W-1:0]    rom_data;
    logic                 step_end;
    logic                 step_final;

    // Free-running tick prescaler; trigger never disturbs its phase.
    assign tick = (presc == 16'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    // ROM is always addressed by the registered effect/step, so the address
    // is stable during FETCH and the word is ready in LOAD.
    sfx_rom #(
        .NUM_SFX (NUM_SFX),
        .STEPS   (STEPS),
        .SFX_IW  (SFX_IW),
        .STEP_IW (STEP_IW)
    ) u_rom (
        .clk  (clk),
        .sfx  (sfx_q),
        .step (step_q),
        .data (rom_data)
    );

    assign step_end   = (state == PLAY) && tick && (dur_cnt == 8'd1);
    assign step_final = last_q || (step_q == STEP_IW'(STEPS - 1));
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (trigger) begin
            next_state = FETCH;
        end else begin
            case (state)
                IDLE:    next_state = IDLE;
                FETCH:   next_state = LOAD;
                LOAD:    next_state = PLAY;
                PLAY: begin
                    if (step_end) begin
                        next_state = step_final ? IDLE : FETCH;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Datapath. Outputs only change in LOAD (new step) or at the end of the
    // final step (mixer muted), so they hold steady across FETCH/LOAD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sfx_q        <= '0;
            step_q       <= '0;
            dur_cnt      <= '0;
            last_q       <= 1'b0;
            done         <= 1'b0;
            lfo_freq     <= '0;
            noise_freq   <= '0;
            vco_freq     <= '0;
            vco_select   <= 1'b0;
            noise_select <= 1'b0;
            lfo_shift    <= '0;
            mixer        <= '0;
        end else begin
            done <= 1'b0;
            if (trigger) begin
                sfx_q  <= sfx_id;
                step_q <= '0;
            end else begin
                case (state)
                    LOAD: begin
                        vco_freq     <= rom_data[VCO_LSB +: VCO_W];
                        noise_freq   <= rom_data[NOISE_LSB +: NOISE_W];
                        lfo_freq     <= rom_data[LFO_LSB +: LFO_W];
                        vco_select   <= rom_data[VSEL_BIT];
                        noise_select <= rom_data[NSEL_BIT];
                        lfo_shift    <= rom_data[SHIFT_LSB +: SHIFT_W];
                        mixer        <= rom_data[MIX_LSB +: MIX_W];
                        last_q       <= rom_data[LAST_BIT];
                        // A zero duration still plays for one tick.
                        dur_cnt      <= (rom_data[DUR_LSB +: DUR_W] == 8'd0) ?
                                        8'd1 : rom_data[DUR_LSB +: DUR_W];
                    end
                    PLAY: begin
                        if (tick) begin
                            dur_cnt <= dur_cnt - 8'd1;
                            if (dur_cnt == 8'd1) begin
                                if (step_final) begin
                                    mixer <= '0;
                                    done  <= 1'b1;
                                end else begin
                                    step_q <= step_q + 1'b1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer with CLK_DIV=4 and the default effect table.
module tb_sfx_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        trigger = 1'b0;
    logic [1:0]  sfx_id = 2'd0;
    logic        busy;
    logic        done;
    logic [9:0]  lfo_freq;
    logic [11:0] noise_freq;
    logic [11:0] vco_freq;
    logic        vco_select;
    logic        noise_select;
    logic [2:0]  lfo_shift;
    logic [2:0]  mixer;

    int total = 0;
    int bad   = 0;
    int pe    = 0;   // posedges since reset release (prescaler phase model)

    logic [11:0] exp_q[$];
    logic [11:0] seen_q[$];
    int nz, dn, glitch, zero_vco, timed_out;

    sfx_sequencer #(
        .CLK_DIV (4),
        .NUM_SFX (4),
        .STEPS   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .trigger      (trigger),
        .sfx_id       (sfx_id),
        .busy         (busy),
        .done         (done),
        .lfo_freq     (lfo_freq),
        .noise_freq   (noise_freq),
        .vco_freq     (vco_freq),
        .vco_select   (vco_select),
        .noise_select (noise_select),
        .lfo_shift    (lfo_shift),
        .mixer        (mixer)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) pe <= 0;
        else        pe <= pe + 1;
    end

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse(input logic [1:0] id);
        @(negedge clk);
        sfx_id  = id;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    // Called on the negedge after the trigger edge N; checks N+1..N+3.
    task automatic latency(input string tag, input logic [11:0] old_vco,
                           input logic [11:0] new_vco, input logic [2:0] new_mix);
        chk({tag, "_busy_n1"}, busy, 1);
        chk({tag, "_hold_n1"}, vco_freq, old_vco);
        chk({tag, "_nodone_n1"}, done, 0);
        @(negedge clk);
        chk({tag, "_hold_n2"}, vco_freq, old_vco);
        @(negedge clk);
        chk({tag, "_vco_n3"}, vco_freq, new_vco);
        chk({tag, "_mix_n3"}, mixer, new_mix);
    endtask

    // Samples every negedge from the current one until busy falls.
    task automatic watch(input string tag, input int budget);
        logic [11:0] last_vco;
        int cyc;
        nz = 0; dn = 0; glitch = 0; zero_vco = 0; timed_out = 0; cyc = 0;
        seen_q.delete();
        seen_q.push_back(vco_freq);
        last_vco = vco_freq;
        forever begin
            if (mixer != 3'd0) nz++;
            if (done) dn++;
            if (busy && mixer == 3'd0) glitch++;
            if (busy && vco_freq == 12'd0) zero_vco++;
            if (vco_freq != last_vco) begin
                seen_q.push_back(vco_freq);
                last_vco = vco_freq;
            end
            if (!busy) break;
            cyc++;
            if (cyc > budget) begin
                timed_out = 1;
                chk({tag, "_timeout"}, busy, 0);
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int idle_bad;
        int wait_dn;
        int ticks;
        int cyc;
        logic [11:0] e;

        // Reset held
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mixer", mixer, 0);
        chk("rst_vco", vco_freq, 0);
        chk("rst_noise", noise_freq, 0);
        chk("rst_lfo", lfo_freq, 0);
        chk("rst_sel", {vco_select, noise_select, lfo_shift}, 0);

        reset = 1'b1;
        idle_bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy || done || mixer != 3'd0) idle_bad++;
        end
        chk("idle_100", idle_bad, 0);

        // sfx0: 3 ticks -> 9..12 PLAY cycles at CLK_DIV=4
        pulse(2'd0);
        latency("sfx0", 12'd0, 12'd250, 3'b001);
        watch("sfx0", 200);
        chk("sfx0_len", (nz >= 9 && nz <= 12), 1);
        chk("sfx0_done", dn, 1);
        chk("sfx0_mute", mixer, 0);
        chk("sfx0_vco_hold", vco_freq, 250);
        @(negedge clk);
        chk("sfx0_done_width", done, 0);

        // sfx1: 100 -> 200 -> 300, 2 ticks each, no gaps
        pulse(2'd1);
        latency("sfx1", 12'd250, 12'd100, 3'b001);
        watch("sfx1", 300);
        exp_q = '{12'd100, 12'd200, 12'd300};
        chk("sfx1_nvals", seen_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            chk("sfx1_val", (i < seen_q.size()) ? seen_q[i] : 12'hfff, e);
        end
        chk("sfx1_glitch", glitch, 0);
        chk("sfx1_zero_vco", zero_vco, 0);
        chk("sfx1_done", dn, 1);
        chk("sfx1_len", (nz >= 19 && nz <= 28), 1);

        // sfx2: duration 0 plays one tick of noise
        pulse(2'd2);
        latency("sfx2", 12'd300, 12'd0, 3'b010);
        watch("sfx2", 100);
        chk("sfx2_len", (nz >= 1 && nz <= 4), 1);
        chk("sfx2_done", dn, 1);
        chk("sfx2_noise", noise_freq, 90);
        chk("sfx2_nsel", {noise_select, vco_select}, 2'b10);

        // sfx3: all 8 steps without a last flag
        pulse(2'd3);
        latency("sfx3", 12'd0, 12'd50, 3'b001);
        watch("sfx3", 500);
        chk("sfx3_nvals", seen_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(12'(50 * (i + 1)));
        end
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            chk("sfx3_val", (i < seen_q.size()) ? seen_q[i] : 12'hfff, e);
        end
        chk("sfx3_glitch", glitch, 0);
        chk("sfx3_done", dn, 1);
        chk("sfx3_len", (nz >= 22 && nz <= 46), 1);

        // Preempt sfx1 during its step 1 with sfx0
        pulse(2'd1);
        latency("pre1", 12'd400, 12'd100, 3'b001);
        wait_dn = 0; cyc = 0;
        while (vco_freq != 12'd200 && cyc < 100) begin
            @(negedge clk);
            if (done) wait_dn++;
            cyc++;
        end
        chk("pre_reach_step1", vco_freq, 200);
        pulse(2'd0);
        latency("pre0", 12'd200, 12'd250, 3'b001);
        watch("pre0", 200);
        chk("pre_nodone_sfx1", wait_dn, 0);
        chk("pre_done", dn, 1);
        chk("pre_len", (nz >= 9 && nz <= 12), 1);

        // Trigger coincident with the final tick of sfx0
        pulse(2'd0);
        latency("co0", 12'd250, 12'd250, 3'b001);
        ticks = 0; cyc = 0; wait_dn = 0;
        forever begin
            if (((pe + 1) % 4) == 0) begin
                if (ticks == 2) begin
                    sfx_id  = 2'd2;
                    trigger = 1'b1;
                    break;
                end
                ticks++;
            end
            if (done) wait_dn++;
            cyc++;
            if (cyc > 100) break;
            @(negedge clk);
        end
        chk("co_found_tick", trigger, 1);
        @(negedge clk);
        trigger = 1'b0;
        chk("co_nodone_e1", done, 0);
        chk("co_busy_e1", busy, 1);
        chk("co_mix_hold", mixer, 3'b001);
        @(negedge clk);
        chk("co_nodone_e2", done, 0);
        @(negedge clk);
        chk("co_noise", noise_freq, 90);
        chk("co_mix_new", mixer, 3'b010);
        chk("co_nodone_e3", done | (wait_dn != 0), 0);
        watch("co2", 100);
        chk("co_done_sfx2", dn, 1);

        // Reset asserted mid-PLAY
        pulse(2'd3);
        latency("rmid", 12'd0, 12'd50, 3'b001);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rmid_mixer", mixer, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_done", done, 0);
        chk("rmid_vco", vco_freq, 0);
        @(negedge clk);
        reset = 1'b1;
        idle_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || done || mixer != 3'd0) idle_bad++;
        end
        chk("rmid_quiet", idle_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
